// File: rtl/elevator_scan_ctrl_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
//   state_e   : controller FSM states (idle / travelling / doors open)
//   DIR_UP/DIR_DOWN : encoding of the dir_up output
//   pick_dir  : direction choice when leaving IDLE (majority side, tie keeps)
//   max2      : small elaboration-time helper for counter sizing
package elevator_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Head for the side holding more calls; on a tie keep the last direction.
  function automatic logic pick_dir(input int n_up, input int n_dn, input logic keep);
    if (n_up > n_dn) begin
      return DIR_UP;
    end else if (n_dn > n_up) begin
      return DIR_DOWN;
    end else begin
      return keep;
    end
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elevator_scan_ctrl_side_count.sv
// Combinational call census relative to the car position.
//   pending_i  : latched calls, one bit per floor
//   floor_i    : current car floor
//   above_o / below_o     : any call strictly above / below the car
//   n_above_o / n_below_o : number of calls strictly above / below the car
module elevator_scan_ctrl_side_count #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 3
) (
  input  logic [NUM_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]    floor_i,
  output logic                  above_o,
  output logic                  below_o,
  output logic [FLOOR_W:0]      n_above_o,
  output logic [FLOOR_W:0]      n_below_o
);

  // Population counts on either side; the car's own floor belongs to neither.
  always_comb begin
    n_above_o = '0;
    n_below_o = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (pending_i[f] && (f > int'(floor_i))) begin
        n_above_o = n_above_o + (FLOOR_W+1)'(1);
      end else if (pending_i[f] && (f < int'(floor_i))) begin
        n_below_o = n_below_o + (FLOOR_W+1)'(1);
      end else begin
        n_above_o = n_above_o;
      end
    end
  end

  assign above_o = |n_above_o;
  assign below_o = |n_below_o;

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN-policy elevator controller.
//   clk, reset        : clock, asynchronous active-high reset
//   call_req_i        : per-floor call requests, OR-ed into pending
//   door_hold_i       : keeps the door open (dwell reloads) while high
//   current_floor_o   : floor the car is at or last passed
//   dir_up_o          : last committed direction (1 = up)
//   moving_o          : car travelling between floors
//   door_open_o       : door open at current floor
//   arrive_o          : one-cycle pulse on each floor change
//   pending_o         : outstanding calls
// Travel timing: each floor takes MOVE_CYCLES. The cycle right after an
// arrival is the decision cycle (stop / continue / reverse); the leg timer
// keeps running through it, so consecutive arrivals stay MOVE_CYCLES apart.
module elevator_scan_ctrl
  import elevator_scan_ctrl_pkg::*;
#(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1,
  parameter int MOVE_CYCLES = 16,
  parameter int DOOR_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req_i,
  input  logic                  door_hold_i,
  output logic [FLOOR_W-1:0]    current_floor_o,
  output logic                  dir_up_o,
  output logic                  moving_o,
  output logic                  door_open_o,
  output logic                  arrive_o,
  output logic [NUM_FLOORS-1:0] pending_o
);

  localparam int                 TMR_W     = $clog2(max2(MOVE_CYCLES, DOOR_CYCLES) + 1);
  localparam logic [TMR_W-1:0]   MOVE_LOAD = TMR_W'(MOVE_CYCLES - 1);
  localparam logic [TMR_W-1:0]   DOOR_LOAD = TMR_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  state_e                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic                    dir_q, dir_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic                    arrive_q, arrive_d;
  logic [NUM_FLOORS-1:0]   pend_q, pend_d;

  logic                    above_s, below_s, here_s, ahead_s, behind_s, hold_s;
  logic [FLOOR_W:0]        n_above_s, n_below_s;

  elevator_scan_ctrl_side_count #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_side (
    .pending_i (pend_q),
    .floor_i   (floor_q),
    .above_o   (above_s),
    .below_o   (below_s),
    .n_above_o (n_above_s),
    .n_below_o (n_below_s)
  );

  assign here_s   = pend_q[floor_q];
  assign ahead_s  = (dir_q == DIR_UP) ? above_s : below_s;
  assign behind_s = (dir_q == DIR_UP) ? below_s : above_s;
  // A fresh call for the floor the door is open at just extends the dwell.
  assign hold_s   = door_hold_i | call_req_i[floor_q];

  // Next-state, timer, position and pending-call computation.
  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    tmr_d    = tmr_q;
    arrive_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (here_s) begin
          state_d = ST_DOOR;
          tmr_d   = DOOR_LOAD;
        end else if (above_s | below_s) begin
          state_d = ST_MOVE;
          dir_d   = pick_dir(int'(n_above_s), int'(n_below_s), dir_q);
          tmr_d   = MOVE_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MOVE: begin
        if (arrive_q && here_s) begin
          state_d = ST_DOOR;
          tmr_d   = DOOR_LOAD;
        end else if (arrive_q && !ahead_s && !behind_s) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else begin
          // SCAN: turn round only on an arrival with nothing left ahead.
          if (arrive_q && !ahead_s) begin
            dir_d = ~dir_q;
          end else begin
            dir_d = dir_q;
          end
          if (tmr_q == '0) begin
            if ((dir_d == DIR_UP) && (floor_q != TOP_FLOOR)) begin
              floor_d = floor_q + FLOOR_W'(1);
            end else if ((dir_d == DIR_DOWN) && (floor_q != '0)) begin
              floor_d = floor_q - FLOOR_W'(1);
            end else begin
              floor_d = floor_q;
            end
            arrive_d = 1'b1;
            tmr_d    = MOVE_LOAD;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
      end
      ST_DOOR: begin
        if (hold_s) begin
          tmr_d = DOOR_LOAD;
        end else if (tmr_q == '0) begin
          if (ahead_s) begin
            state_d = ST_MOVE;
            tmr_d   = MOVE_LOAD;
          end else if (behind_s) begin
            state_d = ST_MOVE;
            dir_d   = ~dir_q;
            tmr_d   = MOVE_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase

    // Set wins everywhere except the car's floor while the door is (or is about to be) open.
    pend_d = pend_q | call_req_i;
    if (state_d == ST_DOOR) begin
      pend_d[floor_q] = 1'b0;
    end else begin
      pend_d = pend_d;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      floor_q  <= '0;
      dir_q    <= DIR_UP;
      tmr_q    <= '0;
      arrive_q <= 1'b0;
      pend_q   <= '0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      tmr_q    <= tmr_d;
      arrive_q <= arrive_d;
      pend_q   <= pend_d;
    end
  end

  assign current_floor_o = floor_q;
  assign dir_up_o        = dir_q;
  assign moving_o        = (state_q == ST_MOVE);
  assign door_open_o     = (state_q == ST_DOOR);
  assign arrive_o        = arrive_q;
  assign pending_o       = pend_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
module tb_elevator_scan_ctrl;

  localparam int NF = 8;
  localparam int MC = 4;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] call_req;
  logic          door_hold;
  logic [2:0]    floor_o;
  logic          dir_o, mov_o, door_o, arr_o;
  logic [NF-1:0] pend_o;

  int n_cmp = 0;
  int n_err = 0;

  elevator_scan_ctrl #(
    .NUM_FLOORS (NF), .MOVE_CYCLES (MC), .DOOR_CYCLES (DC)
  ) dut (
    .clk (clk), .reset (reset), .call_req_i (call_req), .door_hold_i (door_hold),
    .current_floor_o (floor_o), .dir_up_o (dir_o), .moving_o (mov_o),
    .door_open_o (door_o), .arrive_o (arr_o), .pending_o (pend_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 travelling, 2 doors open.
  // left = cycles still to spend in the current leg / dwell, including this one.
  int            m_car, m_phase, m_left;
  bit            m_up, m_arr;
  logic [NF-1:0] m_calls;

  task automatic model_reset();
    m_car = 0; m_up = 1'b1; m_phase = 0; m_left = 0; m_arr = 1'b0; m_calls = '0;
  endtask

  task automatic model_step(input logic [NF-1:0] c, input logic h);
    int n_up, n_dn, np, nl, nc;
    bit here, ahead, behind, nu, na;
    n_up = 0; n_dn = 0;
    for (int f = 0; f < NF; f++) begin
      if (m_calls[f] && f > m_car) n_up++;
      if (m_calls[f] && f < m_car) n_dn++;
    end
    here   = m_calls[m_car];
    ahead  = m_up ? (n_up > 0) : (n_dn > 0);
    behind = m_up ? (n_dn > 0) : (n_up > 0);
    np = m_phase; nl = m_left; nc = m_car; nu = m_up; na = 1'b0;
    if (m_phase == 0) begin
      if (here) begin np = 2; nl = DC; end
      else if (n_up + n_dn > 0) begin
        np = 1; nl = MC;
        if (n_up > n_dn) nu = 1'b1;
        else if (n_dn > n_up) nu = 1'b0;
      end
    end else if (m_phase == 1) begin
      if (m_arr && here) begin np = 2; nl = DC; end
      else if (m_arr && !ahead && !behind) np = 0;
      else begin
        if (m_arr && !ahead) nu = !m_up;
        if (m_left == 1) begin nc = m_car + (nu ? 1 : -1); na = 1'b1; nl = MC; end
        else nl = m_left - 1;
      end
    end else begin
      if (h || c[m_car]) nl = DC;
      else if (m_left == 1) begin
        if (ahead) begin np = 1; nl = MC; end
        else if (behind) begin np = 1; nl = MC; nu = !m_up; end
        else np = 0;
      end else nl = m_left - 1;
    end
    m_calls = m_calls | c;
    if (np == 2) m_calls[m_car] = 1'b0;
    m_phase = np; m_left = nl; m_car = nc; m_up = nu; m_arr = na;
  endtask

  task automatic check_model();
    logic [14:0] got, exp;
    got = {floor_o, dir_o, mov_o, door_o, arr_o, pend_o};
    exp = {3'(m_car), m_up, (m_phase == 1), (m_phase == 2), m_arr, m_calls};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL model t=%0t got flr/dir/mov/door/arr/pend=%h exp=%h", $time, got, exp);
    end
  endtask

  task automatic check_const(input string name, input logic [2:0] f, input logic d,
                             input logic m, input logic o, input logic a, input logic [NF-1:0] p);
    n_cmp++;
    if ({floor_o, dir_o, mov_o, door_o, arr_o, pend_o} !== {f, d, m, o, a, p}) begin
      n_err++;
      $display("FAIL %s got flr=%0d dir=%b mov=%b door=%b arr=%b pend=%h exp flr=%0d dir=%b mov=%b door=%b arr=%b pend=%h",
               name, floor_o, dir_o, mov_o, door_o, arr_o, pend_o, f, d, m, o, a, p);
    end
  endtask

  task automatic tick(input logic [NF-1:0] c, input logic h);
    call_req = c; door_hold = h;
    @(posedge clk); #1;
    model_step(c, h);
    check_model();
  endtask

  typedef struct {
    logic [NF-1:0] call; logic hold; int n;
    logic [2:0] f; logic d; logic m; logic o; logic a; logic [NF-1:0] p;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // call, hold, ticks | expected floor, dir, moving, door, arrive, pending
    vecs.push_back(vec_t'{8'h01, 1'b0, 1,  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01}); // call at idle floor
    vecs.push_back(vec_t'{8'h00, 1'b0, 1,  3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00}); // door on 2nd edge
    vecs.push_back(vec_t'{8'h00, 1'b0, 2,  3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1,  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}); // 3-cycle dwell
    vecs.push_back(vec_t'{8'h20, 1'b0, 1,  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20}); // trip to 5
    vecs.push_back(vec_t'{8'h00, 1'b0, 1,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h20});
    vecs.push_back(vec_t'{8'h00, 1'b0, 4,  3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h20});
    vecs.push_back(vec_t'{8'h00, 1'b0, 4,  3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'h20});
    vecs.push_back(vec_t'{8'h00, 1'b0, 12, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 8'h20});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1,  3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00});
    vecs.push_back(vec_t'{8'h00, 1'b0, 3,  3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    vecs.push_back(vec_t'{8'h80, 1'b0, 1,  3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80}); // up to 7, call 2 mid-trip
    vecs.push_back(vec_t'{8'h00, 1'b0, 5,  3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80});
    vecs.push_back(vec_t'{8'h04, 1'b0, 1,  3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 8'h84});
    vecs.push_back(vec_t'{8'h00, 1'b0, 3,  3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 8'h84});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1,  3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 8'h04});
    vecs.push_back(vec_t'{8'h00, 1'b0, 3,  3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04}); // reverse at top
    vecs.push_back(vec_t'{8'h00, 1'b0, 20, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'h04});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1,  3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    vecs.push_back(vec_t'{8'h00, 1'b0, 3,  3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    vecs.push_back(vec_t'{8'h10, 1'b0, 1,  3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10}); // reposition to 4
    vecs.push_back(vec_t'{8'h00, 1'b0, 9,  3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10});
    vecs.push_back(vec_t'{8'h00, 1'b0, 4,  3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    vecs.push_back(vec_t'{8'h46, 1'b0, 1,  3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h46}); // {1,2,6}: majority down
    vecs.push_back(vec_t'{8'h00, 1'b0, 1,  3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 8'h46});
    vecs.push_back(vec_t'{8'h00, 1'b0, 9,  3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h42});
    vecs.push_back(vec_t'{8'h00, 1'b0, 8,  3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40});
    vecs.push_back(vec_t'{8'h00, 1'b0, 3,  3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40});
    vecs.push_back(vec_t'{8'h00, 1'b0, 21, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00});
    vecs.push_back(vec_t'{8'h00, 1'b0, 3,  3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    vecs.push_back(vec_t'{8'h08, 1'b0, 1,  3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 8'h08}); // door hold at 3
    vecs.push_back(vec_t'{8'h00, 1'b0, 13, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 8'h08});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1,  3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    vecs.push_back(vec_t'{8'h00, 1'b1, 10, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    vecs.push_back(vec_t'{8'h00, 1'b0, 2,  3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1,  3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});

    reset = 1'b1; call_req = '0; door_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_const("reset_state", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    model_reset();

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) tick((k == 0) ? vecs[i].call : '0, vecs[i].hold);
      check_const($sformatf("vec%0d", i), vecs[i].f, vecs[i].d, vecs[i].m, vecs[i].o, vecs[i].a, vecs[i].p);
    end

    // Asynchronous reset in the middle of a move up from floor 3.
    tick(8'h80, 1'b0);
    repeat (3) tick(8'h00, 1'b0);
    check_const("mid_move", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80);
    #2 reset = 1'b1;
    #1;
    check_const("async_reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    check_const("reset_hold", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    model_reset();

    // Randomised traffic against the reference model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [NF-1:0] c;
      logic          h;
      c = ($urandom_range(0, 11) == 0) ? NF'($urandom) & NF'($urandom) : '0;
      h = ($urandom_range(0, 19) == 0);
      tick(c, h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
